maxpool2d_11_11_64_to_5_5_64: RTL and testbench

Second max-pool stage of the MNIST CNN. It sits directly downstream of the 13x13x32->11x11x64 conv2d stage. On start it triggers the conv stage, waits for its done, then reads the 11x11x64 int8 feature map through the conv stage's byte read port. It applies 2x2 stride-2 max pooling (floor mode, so row/col 10 are dropped), stores the 5x5x64 result internally, and exposes it through an identical byte read port to the next layer (flatten/dense).

---
 rtl/maxpool2d_11_11_64_to_5_5_64.sv | 187 ++++++++++++++++++
 tb/tb_maxpool2d_11_11_64_to_5_5_64.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2d_11_11_64_to_5_5_64.sv
// 2x2 stride-2 max pool of the 11x11x64 int8 conv output into a 5x5x64 buffer.
// Drives the upstream conv stage, streams its map through a byte port and serves a byte read port.
module maxpool2d_11_11_64_to_5_5_64 #(
  parameter int unsigned IN_H   = 11,
  parameter int unsigned IN_W   = 11,
  parameter int unsigned CH     = 64,
  parameter int unsigned OUT_H  = IN_H / 2,
  parameter int unsigned OUT_W  = IN_W / 2,
  parameter int unsigned RD_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] read_addr,
  output logic [7:0]  read_data,
  output logic        done,
  output logic        up_start,
  output logic [31:0] up_addr,
  input  logic [7:0]  up_data,
  input  logic        up_done
);

  localparam int unsigned OutSize = OUT_H * OUT_W * CH;
  localparam int unsigned AddrW   = $clog2(OutSize);
  localparam int unsigned ChW     = $clog2(CH);
  localparam int unsigned XW      = $clog2(OUT_W);
  localparam int unsigned YW      = $clog2(OUT_H);
  localparam int unsigned LatW    = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStartUp,
    StWaitUp,
    StIssue,
    StWait,
    StAcc,
    StWrite,
    StFinish
  } state_e;

  state_e            state_q, state_d;
  logic [ChW-1:0]    c_q, c_d;
  logic [XW-1:0]     px_q, px_d;
  logic [YW-1:0]     py_q, py_d;
  logic [1:0]        k_q, k_d;
  logic [LatW-1:0]   wcnt_q, wcnt_d;
  logic [7:0]        max_q, max_d;
  logic [31:0]       up_addr_q, up_addr_d;

  logic [31:0]       win_y, win_x, win_addr;
  logic [AddrW-1:0]  wr_addr;
  logic              mem_we;
  logic              last_c, last_px, last_py;
  logic              acc_take;

  logic [7:0]        mem [OutSize];

  // k walks the window as (0,0),(0,1),(1,0),(1,1): k[1] is dy, k[0] is dx.
  always_comb begin
    win_y    = 32'(py_q) * 32'd2 + 32'(k_q[1]);
    win_x    = 32'(px_q) * 32'd2 + 32'(k_q[0]);
    win_addr = (win_y * IN_W + win_x) * CH + 32'(c_q);
    wr_addr  = AddrW'((32'(py_q) * OUT_W + 32'(px_q)) * CH + 32'(c_q));
    last_c   = (c_q == ChW'(CH - 1));
    last_px  = (px_q == XW'(OUT_W - 1));
    last_py  = (py_q == YW'(OUT_H - 1));
    acc_take = (k_q == 2'd0) || ($signed(up_data) > $signed(max_q));
  end

  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    px_d      = px_q;
    py_d      = py_q;
    k_d       = k_q;
    wcnt_d    = wcnt_q;
    max_d     = max_q;
    up_addr_d = up_addr_q;
    mem_we    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StStartUp;
      end
      StStartUp: begin
        state_d = StWaitUp;
      end
      StWaitUp: begin
        // Level-sensitive: a conv stage that is already done lets us proceed at once.
        if (up_done) begin
          c_d     = '0;
          px_d    = '0;
          py_d    = '0;
          k_d     = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        up_addr_d = win_addr;
        wcnt_d    = '0;
        state_d   = (RD_LAT > 1) ? StWait : StAcc;
      end
      StWait: begin
        if (wcnt_q == LatW'(RD_LAT - 2)) begin
          state_d = StAcc;
        end else begin
          wcnt_d = wcnt_q + LatW'(1);
        end
      end
      StAcc: begin
        if (acc_take) max_d = up_data;
        if (k_q == 2'd3) begin
          k_d     = '0;
          state_d = StWrite;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = StIssue;
        end
      end
      StWrite: begin
        mem_we  = 1'b1;
        state_d = StIssue;
        if (last_c) begin
          c_d = '0;
          if (last_px) begin
            px_d = '0;
            if (last_py) begin
              state_d = StFinish;
            end else begin
              py_d = py_q + YW'(1);
            end
          end else begin
            px_d = px_q + XW'(1);
          end
        end else begin
          c_d = c_q + ChW'(1);
        end
      end
      StFinish: begin
        if (start) state_d = StStartUp;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      c_q       <= '0;
      px_q      <= '0;
      py_q      <= '0;
      k_q       <= '0;
      wcnt_q    <= '0;
      max_q     <= '0;
      up_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      px_q      <= px_d;
      py_q      <= py_d;
      k_q       <= k_d;
      wcnt_q    <= wcnt_d;
      max_q     <= max_d;
      up_addr_q <= up_addr_d;
    end
  end

  // Pooled buffer: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= max_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      read_data <= '0;
    end else if (read_addr < 32'(OutSize)) begin
      read_data <= mem[read_addr[AddrW-1:0]];
    end else begin
      read_data <= '0;
    end
  end

  assign up_start = (state_q == StStartUp);
  assign done     = (state_q == StFinish);
  assign up_addr  = up_addr_q;

endmodule

// File: tb/tb_maxpool2d_11_11_64_to_5_5_64.sv
// Directed bench for the 11x11x64 -> 5x5x64 max pool: upstream BRAM model with 2-cycle latency,
// vector table of hand-computed reads plus handshake, restart and mid-run reset sequences.
module tb_maxpool2d_11_11_64_to_5_5_64;

  logic        clk = 1'b0;
  logic        resetn, start, up_done;
  logic [31:0] read_addr, up_addr;
  logic [7:0]  read_data, up_data;
  logic        done, up_start;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] up_mem [7744];
  logic [7:0] up_q = 8'h00;
  int up_start_cnt  = 0;
  int up_start_wide = 0;
  logic up_start_prev = 1'b0;
  int addr_chg = 0;
  int hit10    = 0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs[11];

  always #5 clk = ~clk;

  maxpool2d_11_11_64_to_5_5_64 dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .read_addr (read_addr),
    .read_data (read_data),
    .done      (done),
    .up_start  (up_start),
    .up_addr   (up_addr),
    .up_data   (up_data),
    .up_done   (up_done)
  );

  // Upstream port B: address sampled one edge after it changes, data sampled by the DUT one later.
  always @(posedge clk) up_q <= (up_addr < 32'd7744) ? up_mem[up_addr[12:0]] : 8'h00;
  assign up_data = up_q;

  always @(negedge clk) begin
    if (up_start) up_start_cnt++;
    if (up_start && up_start_prev) up_start_wide++;
    up_start_prev = up_start;
  end

  always @(up_addr) begin
    addr_chg++;
    if ((up_addr / 704) >= 10 || ((up_addr / 64) % 11) >= 10) hit10++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input int idx);
    int c, p, px, py;
    logic signed [7:0] m, v;
    c  = idx % 64;
    p  = idx / 64;
    px = p % 5;
    py = p / 5;
    m  = up_mem[((2 * py) * 11 + 2 * px) * 64 + c];
    for (int k = 1; k < 4; k++) begin
      v = up_mem[((2 * py + k / 2) * 11 + 2 * px + k % 2) * 64 + c];
      if (v > m) m = v;
    end
    return m;
  endfunction

  task automatic do_read(input logic [31:0] a, output logic [7:0] d);
    @(negedge clk) read_addr = a;
    @(posedge clk);
    #1 d = read_data;
  endtask

  task automatic sweep_model(input string name);
    int bad = 0;
    logic [7:0] d;
    for (int i = 0; i < 1600; i++) begin
      do_read(i, d);
      if (d !== model(i)) begin
        if (bad == 0) $display("  %s: first bad index %0d got %0h want %0h", name, i, d, model(i));
        bad++;
      end
    end
    check(name, bad, 0);
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while (!done && cyc < 1600 * 13 + 10) begin
      @(posedge clk);
      #1 cyc++;
    end
    check({name, "_done"}, done, 1);
    check({name, "_latency_ok"}, (cyc <= 1600 * 13 + 2), 1);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic fill_basic();
    for (int y = 0; y < 11; y++)
      for (int x = 0; x < 11; x++)
        for (int c = 0; c < 64; c++)
          up_mem[(y * 11 + x) * 64 + c] = 8'((y * 11 + x + c) & 8'h7F);
  endtask

  task automatic run_table(input string tag);
    logic [7:0] d;
    for (int i = 0; i < 11; i++) begin
      do_read(vecs[i].addr, d);
      check({tag, "_", vecs[i].name}, d, vecs[i].exp);
    end
  endtask

  initial begin
    int bad, n, chg0, cnt0;
    logic [7:0] d;

    vecs[0]  = '{"a0",     32'd0,    8'd12};
    vecs[1]  = '{"a1",     32'd1,    8'd13};
    vecs[2]  = '{"a63",    32'd63,   8'd75};
    vecs[3]  = '{"a64",    32'd64,   8'd14};
    vecs[4]  = '{"a127",   32'd127,  8'd77};
    vecs[5]  = '{"a320",   32'd320,  8'd34};
    vecs[6]  = '{"a842",   32'd842,  8'd72};
    vecs[7]  = '{"a1536",  32'd1536, 8'd108};
    vecs[8]  = '{"a1599",  32'd1599, 8'd43};
    vecs[9]  = '{"oor1600", 32'd1600, 8'd0};
    vecs[10] = '{"oor4095", 32'd4095, 8'd0};

    resetn = 1'b0; start = 1'b0; up_done = 1'b0; read_addr = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", done, 0);
    check("rst_up_start", up_start, 0);
    check("rst_up_addr", up_addr, 0);
    check("rst_read_data", read_data, 0);
    @(negedge clk) resetn = 1'b1;

    // Handshake: conv stage stays busy for 500 cycles; a stray start meanwhile is ignored.
    fill_basic();
    pulse_start();
    chg0 = addr_chg;
    bad  = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      start = (i == 10);
      if (done) bad++;
    end
    start = 1'b0;
    check("wait_up_no_addr_change", addr_chg, chg0);
    check("wait_up_done_low", bad, 0);
    check("single_up_start", up_start_cnt, 1);
    @(negedge clk) up_done = 1'b1;
    wait_done("basic");
    run_table("basic");
    check("basic_no_row_col_10", hit10, 0);
    sweep_model("basic_sweep");

    // Restart with floor-boundary data and two signed windows in channels 5 and 6.
    for (int y = 0; y < 11; y++)
      for (int x = 0; x < 11; x++)
        for (int c = 0; c < 64; c++)
          up_mem[(y * 11 + x) * 64 + c] = (y == 10 || x == 10) ? 8'h7F : 8'h10;
    up_mem[5] = 8'h80; up_mem[69] = 8'hFF; up_mem[709] = 8'h7F; up_mem[773] = 8'h00;
    up_mem[6] = 8'h80; up_mem[70] = 8'hFE; up_mem[710] = 8'hFF; up_mem[774] = 8'h81;
    hit10 = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 check("restart_done_drops", done, 0);
    @(negedge clk) start = 1'b0;
    wait_done("restart");
    check("restart_up_start_cnt", up_start_cnt, 2);
    check("floor_no_row_col_10", hit10, 0);
    do_read(32'd5, d);
    check("signed_win_a", d, 8'h7F);
    do_read(32'd6, d);
    check("signed_win_b", d, 8'hFF);
    bad = 0;
    for (int i = 0; i < 1600; i++) begin
      do_read(i, d);
      if (d !== ((i == 5) ? 8'h7F : (i == 6) ? 8'hFF : 8'h10)) bad++;
    end
    check("floor_sweep_const", bad, 0);

    // Abort at output index 700 (py=2, px=0, c=60 -> first window byte at up_addr 2876).
    fill_basic();
    pulse_start();
    n = 0;
    while (up_addr !== 32'd2876 && n < 30000) begin
      @(posedge clk);
      #1 n++;
    end
    check("reached_index_700", up_addr, 32'd2876);
    @(negedge clk) resetn = 1'b0;
    #1;
    check("abort_done", done, 0);
    check("abort_up_addr", up_addr, 0);
    check("abort_up_start", up_start, 0);
    @(negedge clk) resetn = 1'b1;
    chg0 = addr_chg;
    cnt0 = up_start_cnt;
    bad  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) bad++;
    end
    check("idle_no_addr_activity", addr_chg, chg0);
    check("idle_no_up_start", up_start_cnt, cnt0);
    check("idle_done_low", bad, 0);
    pulse_start();
    wait_done("rerun");
    check("rerun_up_start_cnt", up_start_cnt, cnt0 + 1);
    run_table("rerun");
    sweep_model("rerun_sweep");
    check("up_start_single_cycle", up_start_wide, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
